// File: rtl/fx_pkg.sv
// Shared widths, op encoding, port ids and FSM states for the fx bus arbiter.
package fx_pkg;
   localparam int FX_AW = 22;
   localparam int FX_DW = 8;

   localparam logic OP_WR  = 1'b1;
   localparam logic OP_RD  = 1'b0;
   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RLAT  = 2'd2,
      S_RESP  = 2'd3
   } fx_state_e;

   typedef struct packed {
      logic             op;
      logic [FX_AW-1:0] addr;
      logic [FX_DW-1:0] data;
   } fx_req_t;
endpackage

// File: rtl/fx_arb_slot.sv
// One-deep pending op buffer for a single requester, with a sticky drop flag.
module fx_arb_slot
   import fx_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wr_i,
   input  logic [FX_AW-1:0] waddr_i,
   input  logic [FX_DW-1:0] data_i,
   input  logic             rd_i,
   input  logic [FX_AW-1:0] raddr_i,
   input  logic             grant_i,
   output logic             pend_o,
   output fx_req_t          req_o,
   output logic             ovf_o
);
   logic    pend_q, pend_d;
   logic    ovf_q, ovf_d;
   fx_req_t req_q, req_d;
   logic    take_s;

   // A pulse landing on the grant edge refills the slot: set wins over clear.
   always_comb begin
      take_s = (wr_i | rd_i) & (~pend_q | grant_i);
      pend_d = pend_q & ~grant_i;
      req_d  = req_q;
      if (take_s) begin
         pend_d = 1'b1;
         if (wr_i) begin
            req_d = '{op: OP_WR, addr: waddr_i, data: data_i};
         end else begin
            req_d = '{op: OP_RD, addr: raddr_i, data: {FX_DW{1'b0}}};
         end
      end else begin
         req_d = req_q;
      end
      if ((wr_i & rd_i) | ((wr_i | rd_i) & ~take_s)) begin
         ovf_d = 1'b1;
      end else begin
         ovf_d = ovf_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pend_q <= 1'b0;
         ovf_q  <= 1'b0;
         req_q  <= '{op: OP_RD, addr: {FX_AW{1'b0}}, data: {FX_DW{1'b0}}};
      end else begin
         pend_q <= pend_d;
         ovf_q  <= ovf_d;
         req_q  <= req_d;
      end
   end

   assign pend_o = pend_q;
   assign req_o  = req_q;
   assign ovf_o  = ovf_q;
endmodule

// File: rtl/fx_arb.sv
// Two-requester round-robin arbiter serialising single-cycle fx ops onto one slave bus.
module fx_arb
   import fx_pkg::*;
#(
   parameter int unsigned RD_LAT = 1
)
(
   input  logic             clk_sys,
   input  logic             rst,
   input  logic             a_wr,
   input  logic [FX_AW-1:0] a_waddr,
   input  logic [FX_DW-1:0] a_data,
   input  logic             a_rd,
   input  logic [FX_AW-1:0] a_raddr,
   output logic [FX_DW-1:0] a_q,
   output logic             a_q_vld,
   output logic             a_busy,
   output logic             a_ovf,
   input  logic             b_wr,
   input  logic [FX_AW-1:0] b_waddr,
   input  logic [FX_DW-1:0] b_data,
   input  logic             b_rd,
   input  logic [FX_AW-1:0] b_raddr,
   output logic [FX_DW-1:0] b_q,
   output logic             b_q_vld,
   output logic             b_busy,
   output logic             b_ovf,
   output logic             fx_wr,
   output logic [FX_DW-1:0] fx_data,
   output logic [FX_AW-1:0] fx_waddr,
   output logic             fx_rd,
   output logic [FX_AW-1:0] fx_raddr,
   input  logic [FX_DW-1:0] fx_q
);
   localparam logic [3:0] RLAT_INIT = 4'(RD_LAT - 32'd1);

   logic      a_pend_s, b_pend_s, a_grant_s, b_grant_s, gnt_sel_s, any_pend_s;
   fx_req_t   a_req_s, b_req_s, gnt_req_s;
   fx_state_e state_q;
   logic      sel_q, last_q, op_q;
   logic [3:0] cnt_q;
   logic      fx_wr_q, fx_rd_q, a_q_vld_q, b_q_vld_q;
   logic [FX_AW-1:0] fx_waddr_q, fx_raddr_q;
   logic [FX_DW-1:0] fx_data_q, a_q_q, b_q_q;

   fx_arb_slot u_slot_a (
      .clk_i(clk_sys), .rst_i(rst), .wr_i(a_wr), .waddr_i(a_waddr), .data_i(a_data),
      .rd_i(a_rd), .raddr_i(a_raddr), .grant_i(a_grant_s),
      .pend_o(a_pend_s), .req_o(a_req_s), .ovf_o(a_ovf)
   );

   fx_arb_slot u_slot_b (
      .clk_i(clk_sys), .rst_i(rst), .wr_i(b_wr), .waddr_i(b_waddr), .data_i(b_data),
      .rd_i(b_rd), .raddr_i(b_raddr), .grant_i(b_grant_s),
      .pend_o(b_pend_s), .req_o(b_req_s), .ovf_o(b_ovf)
   );

   // When both wait, the port that did not win last time goes first.
   always_comb begin
      any_pend_s = a_pend_s | b_pend_s;
      if (a_pend_s & b_pend_s) begin
         gnt_sel_s = ~last_q;
      end else begin
         gnt_sel_s = b_pend_s;
      end
      gnt_req_s = (gnt_sel_s == PORT_B) ? b_req_s : a_req_s;
      a_grant_s = (state_q == S_IDLE) & any_pend_s & (gnt_sel_s == PORT_A);
      b_grant_s = (state_q == S_IDLE) & any_pend_s & (gnt_sel_s == PORT_B);
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         state_q    <= S_IDLE;
         sel_q      <= PORT_A;
         last_q     <= PORT_A;
         op_q       <= OP_RD;
         cnt_q      <= 4'd0;
         fx_wr_q    <= 1'b0;
         fx_rd_q    <= 1'b0;
         fx_waddr_q <= {FX_AW{1'b0}};
         fx_raddr_q <= {FX_AW{1'b0}};
         fx_data_q  <= {FX_DW{1'b0}};
         a_q_q      <= {FX_DW{1'b0}};
         b_q_q      <= {FX_DW{1'b0}};
         a_q_vld_q  <= 1'b0;
         b_q_vld_q  <= 1'b0;
      end else begin
         fx_wr_q    <= 1'b0;
         fx_rd_q    <= 1'b0;
         fx_waddr_q <= {FX_AW{1'b0}};
         fx_raddr_q <= {FX_AW{1'b0}};
         fx_data_q  <= {FX_DW{1'b0}};
         a_q_vld_q  <= 1'b0;
         b_q_vld_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (any_pend_s) begin
                  state_q <= S_ISSUE;
                  sel_q   <= gnt_sel_s;
                  last_q  <= gnt_sel_s;
                  op_q    <= gnt_req_s.op;
                  if (gnt_req_s.op == OP_WR) begin
                     fx_wr_q    <= 1'b1;
                     fx_waddr_q <= gnt_req_s.addr;
                     fx_data_q  <= gnt_req_s.data;
                  end else begin
                     fx_rd_q    <= 1'b1;
                     fx_raddr_q <= gnt_req_s.addr;
                  end
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_ISSUE: begin
               if (op_q == OP_WR) begin
                  state_q <= S_IDLE;
               end else if (RD_LAT == 32'd1) begin
                  state_q <= S_RESP;
               end else begin
                  state_q <= S_RLAT;
                  cnt_q   <= RLAT_INIT;
               end
            end
            S_RLAT: begin
               if (cnt_q == 4'd1) begin
                  state_q <= S_RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_RESP: begin
               state_q <= S_IDLE;
               if (sel_q == PORT_B) begin
                  b_q_q     <= fx_q;
                  b_q_vld_q <= 1'b1;
               end else begin
                  a_q_q     <= fx_q;
                  a_q_vld_q <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign a_busy   = a_pend_s | ((state_q != S_IDLE) & (sel_q == PORT_A));
   assign b_busy   = b_pend_s | ((state_q != S_IDLE) & (sel_q == PORT_B));
   assign fx_wr    = fx_wr_q;
   assign fx_rd    = fx_rd_q;
   assign fx_waddr = fx_waddr_q;
   assign fx_raddr = fx_raddr_q;
   assign fx_data  = fx_data_q;
   assign a_q      = a_q_q;
   assign b_q      = b_q_q;
   assign a_q_vld  = a_q_vld_q;
   assign b_q_vld  = b_q_vld_q;
endmodule

// File: tb/tb_fx_arb.sv
// Scoreboard bench for fx_arb: one RD_LAT=1 and one RD_LAT=4 instance on shared inputs.
module tb_fx_arb;
   typedef struct { int cyc; logic wr; logic [21:0] addr; logic [7:0] data; } bus_t;
   typedef struct { int cyc; logic port_b; logic [7:0] q; } rsp_t;

   logic clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   int cyc = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;

   logic        rst, a_wr, a_rd, b_wr, b_rd;
   logic [21:0] a_waddr, a_raddr, b_waddr, b_raddr;
   logic [7:0]  a_data, b_data, fx_q;
   logic        mon_sel;

   logic        fx_wr, fx_rd, a_q_vld, b_q_vld, a_busy, b_busy, a_ovf, b_ovf;
   logic [21:0] fx_waddr, fx_raddr;
   logic [7:0]  fx_data, a_q, b_q;
   logic        fx_wr_4, fx_rd_4, a_q_vld_4, b_q_vld_4, a_busy_4, b_busy_4, a_ovf_4, b_ovf_4;
   logic [21:0] fx_waddr_4, fx_raddr_4;
   logic [7:0]  fx_data_4, a_q_4, b_q_4;

   fx_arb #(.RD_LAT(1)) u_dut (
      .clk_sys(clk_sys), .rst(rst),
      .a_wr(a_wr), .a_waddr(a_waddr), .a_data(a_data), .a_rd(a_rd), .a_raddr(a_raddr),
      .a_q(a_q), .a_q_vld(a_q_vld), .a_busy(a_busy), .a_ovf(a_ovf),
      .b_wr(b_wr), .b_waddr(b_waddr), .b_data(b_data), .b_rd(b_rd), .b_raddr(b_raddr),
      .b_q(b_q), .b_q_vld(b_q_vld), .b_busy(b_busy), .b_ovf(b_ovf),
      .fx_wr(fx_wr), .fx_data(fx_data), .fx_waddr(fx_waddr), .fx_rd(fx_rd),
      .fx_raddr(fx_raddr), .fx_q(fx_q)
   );

   fx_arb #(.RD_LAT(4)) u_dut4 (
      .clk_sys(clk_sys), .rst(rst),
      .a_wr(a_wr), .a_waddr(a_waddr), .a_data(a_data), .a_rd(a_rd), .a_raddr(a_raddr),
      .a_q(a_q_4), .a_q_vld(a_q_vld_4), .a_busy(a_busy_4), .a_ovf(a_ovf_4),
      .b_wr(b_wr), .b_waddr(b_waddr), .b_data(b_data), .b_rd(b_rd), .b_raddr(b_raddr),
      .b_q(b_q_4), .b_q_vld(b_q_vld_4), .b_busy(b_busy_4), .b_ovf(b_ovf_4),
      .fx_wr(fx_wr_4), .fx_data(fx_data_4), .fx_waddr(fx_waddr_4), .fx_rd(fx_rd_4),
      .fx_raddr(fx_raddr_4), .fx_q(fx_q)
   );

   // Scoreboard watches whichever instance the current test targets.
   logic        m_wr, m_rd, m_avld, m_bvld;
   logic [21:0] m_waddr, m_raddr;
   logic [7:0]  m_data, m_aq, m_bq;
   assign m_wr    = mon_sel ? fx_wr_4    : fx_wr;
   assign m_rd    = mon_sel ? fx_rd_4    : fx_rd;
   assign m_waddr = mon_sel ? fx_waddr_4 : fx_waddr;
   assign m_raddr = mon_sel ? fx_raddr_4 : fx_raddr;
   assign m_data  = mon_sel ? fx_data_4  : fx_data;
   assign m_avld  = mon_sel ? a_q_vld_4  : a_q_vld;
   assign m_bvld  = mon_sel ? b_q_vld_4  : b_q_vld;
   assign m_aq    = mon_sel ? a_q_4      : a_q;
   assign m_bq    = mon_sel ? b_q_4      : b_q;

   bus_t exp_bus[$];
   rsp_t exp_rsp[$];
   int n_cmp = 0;
   int n_err = 0;

   // Slave read data changes every cycle so the sampling cycle is visible in the result.
   function automatic logic [7:0] pat(input int c);
      logic [31:0] t;
      t = 32'(c) * 32'd29;
      return t[7:0] ^ 8'hC3;
   endfunction

   task automatic step();
      bus_t eb;
      rsp_t er;
      logic [53:0] bgot, breq;
      logic [9:0]  rgot, rreq;
      @(posedge clk_sys);
      #1;
      fx_q = pat(cyc);
      while (exp_bus.size() > 0 && exp_bus[0].cyc < cyc) begin
         n_cmp++; n_err++;
         $display("FAIL bus_missing: no op seen, required wr=%b addr=%h data=%h in cycle %0d",
                  exp_bus[0].wr, exp_bus[0].addr, exp_bus[0].data, exp_bus[0].cyc);
         void'(exp_bus.pop_front());
      end
      if (m_wr || m_rd) begin
         n_cmp++;
         bgot = {m_wr, m_rd, m_waddr, m_raddr, m_data};
         if (exp_bus.size() == 0) begin
            n_err++;
            $display("FAIL bus_unexpected: cycle %0d got %h, required no op", cyc, bgot);
         end else begin
            eb = exp_bus.pop_front();
            breq = {eb.wr, ~eb.wr, eb.wr ? eb.addr : 22'h0, eb.wr ? 22'h0 : eb.addr, eb.data};
            if (eb.cyc != cyc || bgot !== breq) begin
               n_err++;
               $display("FAIL bus_op: got cycle %0d %h, required cycle %0d %h", cyc, bgot, eb.cyc, breq);
            end
         end
      end else begin
         n_cmp++;
         if ({m_waddr, m_raddr, m_data} !== 52'h0) begin
            n_err++;
            $display("FAIL bus_idle: cycle %0d fields %h, required 0", cyc, {m_waddr, m_raddr, m_data});
         end
      end
      while (exp_rsp.size() > 0 && exp_rsp[0].cyc < cyc) begin
         n_cmp++; n_err++;
         $display("FAIL rsp_missing: no q_vld seen, required port_b=%b q=%h in cycle %0d",
                  exp_rsp[0].port_b, exp_rsp[0].q, exp_rsp[0].cyc);
         void'(exp_rsp.pop_front());
      end
      if (m_avld || m_bvld) begin
         n_cmp++;
         rgot = {m_avld, m_bvld, m_avld ? m_aq : m_bq};
         if (exp_rsp.size() == 0) begin
            n_err++;
            $display("FAIL rsp_unexpected: cycle %0d got %h, required none", cyc, rgot);
         end else begin
            er = exp_rsp.pop_front();
            rreq = {~er.port_b, er.port_b, er.q};
            if (er.cyc != cyc || rgot !== rreq) begin
               n_err++;
               $display("FAIL rsp: got cycle %0d %h, required cycle %0d %h", cyc, rgot, er.cyc, rreq);
            end
         end
      end
   endtask

   task automatic clear_inputs();
      a_wr = 1'b0; a_rd = 1'b0; b_wr = 1'b0; b_rd = 1'b0;
      a_waddr = 22'h0; a_raddr = 22'h0; b_waddr = 22'h0; b_raddr = 22'h0;
      a_data = 8'h0; b_data = 8'h0;
   endtask

   task automatic do_reset(input logic sel);
      rst = 1'b1;
      clear_inputs();
      step();
      mon_sel = sel;
      step();
      rst = 1'b0;
      exp_bus.delete();
      exp_rsp.delete();
   endtask

   task automatic drain_check(input string name);
      n_cmp++;
      if (exp_bus.size() != 0 || exp_rsp.size() != 0) begin
         n_err++;
         $display("FAIL %s_drain: %0d bus / %0d rsp outstanding, required 0 / 0", name,
                  exp_bus.size(), exp_rsp.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; mon_sel = 1'b0;
      clear_inputs();
      a_wr = 1'b1; a_waddr = 22'h3F_FFFF; a_data = 8'hFF; b_rd = 1'b1; b_raddr = 22'h2A_AAAA;
      fx_q = 8'h00;
      step(); step();
      n_cmp++;
      if ({fx_wr, fx_rd, fx_waddr, fx_raddr, fx_data, a_q, a_q_vld, a_busy, a_ovf,
           b_q, b_q_vld, b_busy, b_ovf} !== 76'h0) begin
         n_err++;
         $display("FAIL reset_outputs: got %h, required 0", {fx_wr, fx_rd, fx_waddr, fx_raddr,
                  fx_data, a_q, a_q_vld, a_busy, a_ovf, b_q, b_q_vld, b_busy, b_ovf});
      end
      n_cmp++;
      if ({fx_wr_4, fx_rd_4, fx_waddr_4, fx_raddr_4, fx_data_4, a_q_4, a_q_vld_4, a_busy_4,
           a_ovf_4, b_q_4, b_q_vld_4, b_busy_4, b_ovf_4} !== 76'h0) begin
         n_err++;
         $display("FAIL reset_outputs_lat4: got %h, required 0", {fx_wr_4, fx_rd_4, fx_waddr_4,
                  fx_raddr_4, fx_data_4, a_q_4, a_q_vld_4, a_busy_4, a_ovf_4, b_q_4, b_q_vld_4,
                  b_busy_4, b_ovf_4});
      end
      rst = 1'b0;
      clear_inputs();
      repeat (4) step();
      drain_check("reset");
   endtask

   task automatic test_write();
      int n;
      do_reset(1'b0);
      step();
      n = cyc;
      a_wr = 1'b1; a_waddr = 22'h01_0034; a_data = 8'h5A;
      exp_bus.push_back('{cyc: n + 2, wr: 1'b1, addr: 22'h01_0034, data: 8'h5A});
      step();
      clear_inputs();
      n_cmp++;
      if (a_busy !== 1'b1) begin n_err++; $display("FAIL write_busy_pend: a_busy=%b, required 1", a_busy); end
      step(); step();
      n_cmp++;
      if (a_busy !== 1'b0) begin n_err++; $display("FAIL write_busy_done: a_busy=%b, required 0", a_busy); end
      repeat (3) step();
      drain_check("write");
   endtask

   task automatic test_read();
      int n;
      do_reset(1'b0);
      step();
      n = cyc;
      b_rd = 1'b1; b_raddr = 22'h02_0010;
      exp_bus.push_back('{cyc: n + 2, wr: 1'b0, addr: 22'h02_0010, data: 8'h00});
      exp_rsp.push_back('{cyc: n + 4, port_b: 1'b1, q: pat(n + 3)});
      step();
      clear_inputs();
      repeat (6) step();
      n_cmp++;
      if (b_q !== pat(n + 3) || a_q !== 8'h00) begin
         n_err++;
         $display("FAIL read_hold: b_q=%h a_q=%h, required b_q=%h a_q=00", b_q, a_q, pat(n + 3));
      end
      drain_check("read");
   endtask

   task automatic test_round_robin();
      int n;
      do_reset(1'b0);
      for (int r = 0; r < 2; r++) begin
         step();
         n = cyc;
         a_wr = 1'b1; a_waddr = 22'h01_0001 + 22'(r); a_data = 8'hA0 + 8'(r);
         b_wr = 1'b1; b_waddr = 22'h02_0002 + 22'(r); b_data = 8'hB0 + 8'(r);
         exp_bus.push_back('{cyc: n + 2, wr: 1'b1, addr: 22'h02_0002 + 22'(r), data: 8'hB0 + 8'(r)});
         exp_bus.push_back('{cyc: n + 4, wr: 1'b1, addr: 22'h01_0001 + 22'(r), data: 8'hA0 + 8'(r)});
         step();
         clear_inputs();
         repeat (8) step();
      end
      drain_check("round_robin");
   endtask

   task automatic test_overflow();
      int n;
      do_reset(1'b0);
      step();
      n = cyc;
      b_rd = 1'b1; b_raddr = 22'h02_0010;
      exp_bus.push_back('{cyc: n + 2, wr: 1'b0, addr: 22'h02_0010, data: 8'h00});
      exp_rsp.push_back('{cyc: n + 4, port_b: 1'b1, q: pat(n + 3)});
      step();
      clear_inputs();
      a_rd = 1'b1; a_raddr = 22'h01_00F0;
      exp_bus.push_back('{cyc: n + 5, wr: 1'b0, addr: 22'h01_00F0, data: 8'h00});
      exp_rsp.push_back('{cyc: n + 7, port_b: 1'b0, q: pat(n + 6)});
      step();
      clear_inputs();
      a_wr = 1'b1; a_waddr = 22'h01_00AA; a_data = 8'h77;
      n_cmp++;
      if (a_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_before: a_ovf=%b, required 0", a_ovf); end
      step();
      clear_inputs();
      n_cmp++;
      if (a_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set: a_ovf=%b, required 1", a_ovf); end
      repeat (3) step();
      n_cmp++;
      if (a_busy !== 1'b1) begin n_err++; $display("FAIL ovf_busy_flight: a_busy=%b, required 1", a_busy); end
      step();
      n_cmp++;
      if (a_busy !== 1'b0) begin n_err++; $display("FAIL ovf_busy_done: a_busy=%b, required 0", a_busy); end
      repeat (4) step();
      n_cmp++;
      if (a_ovf !== 1'b1 || b_ovf !== 1'b0) begin
         n_err++;
         $display("FAIL ovf_sticky: a_ovf=%b b_ovf=%b, required 1 0", a_ovf, b_ovf);
      end
      drain_check("overflow");
   endtask

   task automatic test_same_cycle();
      int n;
      do_reset(1'b0);
      step();
      n = cyc;
      a_wr = 1'b1; a_waddr = 22'h00_0001; a_data = 8'h01;
      a_rd = 1'b1; a_raddr = 22'h00_0002;
      exp_bus.push_back('{cyc: n + 2, wr: 1'b1, addr: 22'h00_0001, data: 8'h01});
      step();
      clear_inputs();
      n_cmp++;
      if (a_ovf !== 1'b1) begin n_err++; $display("FAIL same_cycle_ovf: a_ovf=%b, required 1", a_ovf); end
      repeat (6) step();
      drain_check("same_cycle");
   endtask

   task automatic test_back_to_back();
      int n;
      do_reset(1'b0);
      step();
      n = cyc;
      a_wr = 1'b1; a_waddr = 22'h10_0000; a_data = 8'h11;
      exp_bus.push_back('{cyc: n + 2, wr: 1'b1, addr: 22'h10_0000, data: 8'h11});
      step();
      a_wr = 1'b1; a_waddr = 22'h20_0000; a_data = 8'h22;
      exp_bus.push_back('{cyc: n + 4, wr: 1'b1, addr: 22'h20_0000, data: 8'h22});
      step();
      clear_inputs();
      repeat (5) step();
      n_cmp++;
      if (a_ovf !== 1'b0) begin n_err++; $display("FAIL b2b_no_ovf: a_ovf=%b, required 0", a_ovf); end
      drain_check("back_to_back");
   endtask

   task automatic test_rdlat4();
      int n;
      do_reset(1'b1);
      step();
      n = cyc;
      a_rd = 1'b1; a_raddr = 22'h3F_FFFF;
      exp_bus.push_back('{cyc: n + 2, wr: 1'b0, addr: 22'h3F_FFFF, data: 8'h00});
      exp_rsp.push_back('{cyc: n + 7, port_b: 1'b0, q: pat(n + 6)});
      step();
      clear_inputs();
      repeat (9) step();
      n_cmp++;
      if (a_q_4 !== pat(n + 6)) begin
         n_err++;
         $display("FAIL rdlat4_hold: a_q=%h, required %h", a_q_4, pat(n + 6));
      end
      drain_check("rdlat4");
   endtask

   task automatic test_reset_midop();
      int n;
      do_reset(1'b1);
      step();
      n = cyc;
      a_rd = 1'b1; a_raddr = 22'h05_1234;
      exp_bus.push_back('{cyc: n + 2, wr: 1'b0, addr: 22'h05_1234, data: 8'h00});
      step();
      clear_inputs();
      step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_cmp++;
      if ({fx_wr_4, fx_rd_4, fx_waddr_4, fx_raddr_4, fx_data_4, a_q_4, a_q_vld_4, a_busy_4,
           a_ovf_4, b_q_4, b_q_vld_4, b_busy_4, b_ovf_4} !== 76'h0) begin
         n_err++;
         $display("FAIL midop_reset_outputs: got %h, required 0", {fx_wr_4, fx_rd_4, fx_waddr_4,
                  fx_raddr_4, fx_data_4, a_q_4, a_q_vld_4, a_busy_4, a_ovf_4, b_q_4, b_q_vld_4,
                  b_busy_4, b_ovf_4});
      end
      step(); step();
      n = cyc;
      b_wr = 1'b1; b_waddr = 22'h2A_5555; b_data = 8'hA5;
      exp_bus.push_back('{cyc: n + 2, wr: 1'b1, addr: 22'h2A_5555, data: 8'hA5});
      step();
      clear_inputs();
      repeat (8) step();
      drain_check("reset_midop");
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      mon_sel = 1'b0;
      fx_q = 8'h00;
      test_reset();
      test_write();
      test_read();
      test_round_robin();
      test_overflow();
      test_same_cycle();
      test_back_to_back();
      test_rdlat4();
      test_reset_midop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/fx_arb.md
Name: fx_arb

Overview:
- Two-requester arbiter for the shared fx register bus (22-bit address = {dev[5:0], addr[15:0]}, 8-bit data).
- Lets two fx bus masters share one slave-side fx bus, for example the host-link command master and a local sequencer.
- Each requester issues single-cycle fx_wr/fx_rd pulses. The arbiter buffers one op per requester, serialises the ops round-robin onto the slave bus, and returns read data to the issuing requester with a valid strobe.

Parameters:
- RD_LAT, 1: cycles from the fx_rd cycle to the cycle in which fx_q is valid. Legal range 1..15.

Ports:
- clk_sys  in  1  system clock
- rst  in  1  synchronous reset, active-high
- a_wr  in  1  port A write pulse
- a_waddr  in  22  port A write address
- a_data  in  8  port A write data
- a_rd  in  1  port A read pulse
- a_raddr  in  22  port A read address
- a_q  out  8  port A read data
- a_q_vld  out  1  port A read data valid, 1-cycle pulse
- a_busy  out  1  port A op pending or in flight
- a_ovf  out  1  port A sticky drop flag
- b_wr, b_waddr, b_data, b_rd, b_raddr, b_q, b_q_vld, b_busy, b_ovf: identical set for port B
- fx_wr  out  1  slave bus write pulse
- fx_data  out  8  slave bus write data
- fx_waddr  out  22  slave bus write address
- fx_rd  out  1  slave bus read pulse
- fx_raddr  out  22  slave bus read address
- fx_q  in  8  slave bus read data

Behaviour:
- Reset values (rst sampled high at clk_sys edge): all outputs 0, pending buffers empty, FSM in S_IDLE, rr pointer = A.
- Capture:
  - Per port, a 1-deep pending register holds {op, addr, data}; op is wr or rd.
  - A wr or rd pulse while pending is empty loads the register at that edge.
  - Pulse while pending is full: op dropped, x_ovf set to 1. x_ovf stays set until rst.
  - wr and rd in the same cycle: the wr is captured, the rd is dropped, x_ovf is set.
  - Pending cleared at the grant edge. A new pulse on the same edge is captured (set wins over clear).
- FSM states: S_IDLE, S_ISSUE, S_RLAT, S_RESP.
  - S_IDLE -> S_ISSUE when any pending is set. At that edge the arbiter latches sel and loads the fx_* output registers from the granted port.
  - Grant rule: only one port pending -> that port. Both pending -> the port not equal to the rr pointer's last grant. The rr pointer updates to the granted port.
  - S_ISSUE lasts 1 cycle, with exactly one of fx_wr/fx_rd = 1. Address and data are valid only in this cycle and are 0 otherwise. Unused address/data fields are 0.
  - S_ISSUE exit: write -> S_IDLE; read with RD_LAT=1 -> S_RESP; read with RD_LAT>1 -> S_RLAT.
  - S_RLAT: a 4-bit counter runs RD_LAT-1 cycles, then the FSM goes to S_RESP.
  - S_RESP is the cycle in which fx_q is valid. At the exit edge: x_q <= fx_q for the selected port and x_q_vld = 1 for exactly one cycle; FSM -> S_IDLE.
  - x_q holds its value until the next read response on that port.
- Latency, uncontended:
  - Request pulse in cycle n -> fx_wr/fx_rd high in cycle n+2.
  - Read data: x_q_vld high in cycle n+3+RD_LAT.
- Throughput: a write occupies 2 cycles (S_ISSUE + S_IDLE). A read occupies RD_LAT+2 cycles.
- x_busy = pending set OR (FSM not S_IDLE AND sel == x).
- rst during S_RLAT/S_RESP aborts the op: no x_q_vld, pending buffers discarded.

Decomposition:
- Shared package fx_pkg:
  - FX_AW = 22, FX_DW = 8
  - op encoding: OP_WR = 1'b1, OP_RD = 1'b0
  - state constants for S_IDLE..S_RESP
- One natural sub-module, fx_arb_slot: the per-port pending register with ovf logic. Instantiated twice.

Test Plan:
- Uncontended write: a_wr pulse in cycle 10, a_waddr=22'h01_0034, a_data=8'h5A -> fx_wr=1 in cycle 12 only, fx_waddr=22'h01_0034, fx_data=8'h5A, fx_rd=0 throughout.
- Uncontended read, RD_LAT=1: b_rd in cycle 10, b_raddr=22'h02_0010; slave drives fx_q=8'hC3 in cycle 13 -> fx_rd=1 in cycle 12, b_q_vld=1 in cycle 14 with b_q=8'hC3, a_q_vld stays 0.
- Contention/round-robin: a_wr and b_wr both in cycle 10 after reset -> B granted first (fx_wr cycle 12, B's address), then A (fx_wr cycle 14). Repeat both in cycle 20 -> B first again, since the last grant was A.
- Overflow: a_rd, then a_wr while port A is still pending and not yet granted (cycle 10 then 11, with port B holding the bus) -> second op never appears on fx bus, a_ovf=1 and stays 1; same-cycle a_wr+a_rd -> only the write issues, a_ovf=1.
- RD_LAT=4 build: read at cycle 10 -> fx_rd cycle 12; fx_q sampled in cycle 16; q_vld in cycle 17.
- Reset mid-op: assert rst during S_RLAT of a read -> all outputs 0 the next cycle, no q_vld; a subsequent write issues normally 2 cycles after its pulse.
